ld4_down_counter: RTL and testbench
===================================

LD4_DOWN_COUNTER -- requirements
Module: ld4_down_counter

Interface
REQ-001 SHALL have parameter RELOAD_EN, default "DISABLED"; on underflow, "ENABLED" reloads Q from D3..D0 and "DISABLED" wraps Q to 4'hF.
REQ-002 SHALL have port CK, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port CD, input, 1, asynchronous active-high reset/clear.
REQ-004 SHALL have ports D0, D1, D2, D3, input, 1 each, parallel load data (D0 = LSB).
REQ-005 SHALL have port BI, input, 1, borrow-in / count enable for cascading (1 = decrement this cycle).
REQ-006 SHALL have port SP, input, 1, clock enable gating load and count.
REQ-007 SHALL have port SD, input, 1, synchronous parallel load select.
REQ-008 SHALL have port BO, output, 1, borrow-out to the next (more significant) stage.
REQ-009 SHALL have port TC, output, 1, registered terminal-count (underflow) pulse.
REQ-010 SHALL have ports Q0, Q1, Q2, Q3, output, 1 each, counter value (Q0 = LSB).

Function
REQ-011 SHALL hold the count Q[3:0] in a 4-bit register; Q outputs are the register bits directly, with no combinational path from D to Q.
REQ-012 SHALL apply this per-edge priority, with CD overriding all: SP=0 -> hold; SP=1, SD=1 -> Q<=D; SP=1, SD=0, BI=1 -> decrement; SP=1, SD=0, BI=0 -> hold.
REQ-013 SHALL decrement modulo 16 when RELOAD_EN="DISABLED": Q=4'h0 with decrement gives Q<=4'hF.
REQ-014 SHALL, when RELOAD_EN="ENABLED" and Q=4'h0 with decrement, load Q<=D instead of 4'hF; nonzero Q decrements normally.
REQ-015 SHALL drive BO = BI AND (Q==4'h0), combinationally, independent of SP and SD, so N stages cascade BO->BI with one-cycle decrement latency across all stages.
REQ-016 SHALL set TC<=1 on an edge where underflow occurs (SP=1, SD=0, BI=1, Q=4'h0), and TC<=0 on every other edge, giving a one-cycle pulse.
REQ-017 SHALL give load priority over underflow: SD=1 with Q=0 and BI=1 loads D and leaves TC=0.
REQ-018 SHALL let SP=0 suppress underflow: TC<=0 and Q holds even while BO=1.
REQ-019 SHALL decrement exactly once per enabled edge; there is no multi-step or saturating mode.

Reset
REQ-020 SHALL, while CD=1 and regardless of CK, immediately force Q=4'h0 and TC=0; BO then equals BI.
REQ-021 SHALL, on CD deassertion, resume operation at the first rising CK edge after it, with no extra recovery cycle.
REQ-022 SHALL abort a load or decrement in progress when CD asserts mid-cycle; no partial state update is retained.

Verification
REQ-023 SHALL cover load-and-count: CD pulse, then SP=1, SD=1, D=4'h3 for one edge, then SD=0, BI=1 -> Q sequence 3,2,1,0,F; TC=1 only in the cycle after the 0->F edge; BO=1 only while Q=0.
REQ-024 SHALL cover reload mode: RELOAD_EN="ENABLED", D=4'h5, start from Q=1 with BI=1 -> Q 1,0,5,4; TC pulses once, on the cycle after the 0->5 edge.
REQ-025 SHALL cover enable/borrow gating: Q=4'h0, SP=0, BI=1 for 3 edges -> Q stays 0, BO=1, TC=0; then SP=1 -> Q=F, TC=1 for one cycle.
REQ-026 SHALL cover load priority: Q=0, BI=1, SP=1, SD=1, D=4'hA -> Q=A, TC=0.
REQ-027 SHALL cover the two-stage cascade: low BO -> high BI, both stages loaded to 8'h01, BI_low=1 -> combined count 01, 00, FF; high stage decrements on the same edge the low stage wraps.
REQ-028 SHALL cover async reset mid-count: CD asserted between clock edges while Q=4'h7 -> Q=0, TC=0 before the next edge; after deassertion, counting resumes from 0 (next decrement -> F, TC=1).

Source files
------------

// File: rtl/ld4_down_counter.sv
// Presettable 4-bit synchronous down counter with borrow cascade and a
// registered terminal-count pulse; underflow either wraps to F or reloads D.
module ld4_down_counter #(
    parameter string RELOAD_EN = "DISABLED"
) (
    input  logic CK,
    input  logic CD,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic BI,
    input  logic SP,
    input  logic SD,
    output logic BO,
    output logic TC,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3
);

    localparam bit ReloadOnUnderflow = (RELOAD_EN == "ENABLED");

    logic [3:0] load_val;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       tc_q;
    logic       tc_d;
    logic       at_zero;

    assign load_val = {D3, D2, D1, D0};
    assign at_zero  = (count_q == 4'h0);

    // Load outranks counting; an underflow only happens on an enabled decrement at zero.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (SP) begin
            if (SD) begin
                count_d = load_val;
            end else if (BI) begin
                if (at_zero) begin
                    tc_d    = 1'b1;
                    count_d = ReloadOnUnderflow ? load_val : 4'hF;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            count_q <= 4'h0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // Borrow-out ignores SP/SD so a chain of stages sees the borrow in the same cycle.
    assign BO = BI & at_zero;
    assign TC = tc_q;
    assign Q0 = count_q[0];
    assign Q1 = count_q[1];
    assign Q2 = count_q[2];
    assign Q3 = count_q[3];

endmodule

// File: tb/tb_ld4_down_counter.sv
// Bench for ld4_down_counter: wrap and reload variants share one stimulus,
// and a two-stage cascade is checked as a single 8-bit counter.
`timescale 1ns/1ps
module tb_ld4_down_counter;

    logic       ck = 1'b0;
    logic       cd = 1'b1;
    logic       sp = 1'b0;
    logic       sd = 1'b0;
    logic       bi = 1'b0;
    logic [3:0] d  = 4'h0;

    logic       cSp  = 1'b0;
    logic       cSd  = 1'b0;
    logic       cBi  = 1'b0;
    logic [3:0] cDlo = 4'h0;
    logic [3:0] cDhi = 4'h0;

    logic [3:0] qDis, qEn, qLo, qHi;
    logic       boDis, boEn, boLo, boHi;
    logic       tcDis, tcEn, tcLo, tcHi;

    int assertCount = 0;
    int failCount   = 0;

    int mDis = 0, mEn = 0, cv = 0;
    int tDis = 0, tEn = 0, tLo = 0, tHi = 0;

    always #5 ck = ~ck;

    ld4_down_counter #(.RELOAD_EN("DISABLED")) uDis (
        .CK(ck), .CD(cd), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .BI(bi), .SP(sp), .SD(sd), .BO(boDis), .TC(tcDis),
        .Q0(qDis[0]), .Q1(qDis[1]), .Q2(qDis[2]), .Q3(qDis[3])
    );

    ld4_down_counter #(.RELOAD_EN("ENABLED")) uEn (
        .CK(ck), .CD(cd), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .BI(bi), .SP(sp), .SD(sd), .BO(boEn), .TC(tcEn),
        .Q0(qEn[0]), .Q1(qEn[1]), .Q2(qEn[2]), .Q3(qEn[3])
    );

    ld4_down_counter #(.RELOAD_EN("DISABLED")) uLo (
        .CK(ck), .CD(cd), .D0(cDlo[0]), .D1(cDlo[1]), .D2(cDlo[2]), .D3(cDlo[3]),
        .BI(cBi), .SP(cSp), .SD(cSd), .BO(boLo), .TC(tcLo),
        .Q0(qLo[0]), .Q1(qLo[1]), .Q2(qLo[2]), .Q3(qLo[3])
    );

    ld4_down_counter #(.RELOAD_EN("DISABLED")) uHi (
        .CK(ck), .CD(cd), .D0(cDhi[0]), .D1(cDhi[1]), .D2(cDhi[2]), .D3(cDhi[3]),
        .BI(boLo), .SP(cSp), .SD(cSd), .BO(boHi), .TC(tcHi),
        .Q0(qHi[0]), .Q1(qHi[1]), .Q2(qHi[2]), .Q3(qHi[3])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: integer counts; the cascade is one 8-bit value mod 256.
    always @(posedge ck or posedge cd) begin
        if (cd) begin
            mDis = 0; mEn = 0; cv = 0;
            tDis = 0; tEn = 0; tLo = 0; tHi = 0;
        end else begin
            tDis = 0; tEn = 0; tLo = 0; tHi = 0;
            if (sp && sd) begin
                mDis = int'(d);
                mEn  = int'(d);
            end else if (sp && bi) begin
                if (mDis == 0) begin tDis = 1; mDis = 15; end
                else mDis = mDis - 1;
                if (mEn == 0) begin tEn = 1; mEn = int'(d); end
                else mEn = mEn - 1;
            end
            if (cSp && cSd) begin
                cv = int'(cDhi) * 16 + int'(cDlo);
            end else if (cSp && cBi) begin
                if (cv % 16 == 0) tLo = 1;
                if (cv == 0) tHi = 1;
                cv = (cv + 255) % 256;
            end
        end
    end

    always @(negedge ck) begin
        checkOutput("disQ",  int'(qDis),  mDis);
        checkOutput("disTC", int'(tcDis), tDis);
        checkOutput("disBO", int'(boDis), (bi && mDis == 0) ? 1 : 0);
        checkOutput("enQ",   int'(qEn),   mEn);
        checkOutput("enTC",  int'(tcEn),  tEn);
        checkOutput("enBO",  int'(boEn),  (bi && mEn == 0) ? 1 : 0);
        checkOutput("casQ",  int'({qHi, qLo}), cv);
        checkOutput("casTClo", int'(tcLo), tLo);
        checkOutput("casTChi", int'(tcHi), tHi);
        checkOutput("casBOlo", int'(boLo), (cBi && cv % 16 == 0) ? 1 : 0);
        checkOutput("casBOhi", int'(boHi), (cBi && cv == 0) ? 1 : 0);
    end

    task automatic applyStimulus(input logic s, input logic l, input logic b, input logic [3:0] dv);
        sp = s; sd = l; bi = b; d = dv;
        @(posedge ck);
        #1;
    endtask

    task automatic applyCascade(input logic s, input logic l, input logic b, input logic [7:0] dv);
        cSp = s; cSd = l; cBi = b; cDhi = dv[7:4]; cDlo = dv[3:0];
        @(posedge ck);
        #1;
    endtask

    // Literal expectations checked against both the DUT and the model.
    task automatic expectDis(input string name, input int q, input int tc);
        checkOutput({name, " dis q"},  int'(qDis),  q);
        checkOutput({name, " dis tc"}, int'(tcDis), tc);
        checkOutput({name, " model q"}, mDis, q);
    endtask

    task automatic expectEn(input string name, input int q, input int tc);
        checkOutput({name, " en q"},  int'(qEn),  q);
        checkOutput({name, " en tc"}, int'(tcEn), tc);
        checkOutput({name, " model en q"}, mEn, q);
    endtask

    initial begin
        cd = 1'b1;
        @(posedge ck);
        #1;
        expectDis("reset", 0, 0);
        expectEn("reset", 0, 0);
        bi = 1'b1;
        #1;
        checkOutput("reset BO follows BI", int'(boDis), 1);
        bi = 1'b0;
        cd = 1'b0;

        // Load 3 then count through underflow.
        applyStimulus(1, 1, 0, 4'h3);
        expectDis("load3", 3, 0);
        applyStimulus(1, 0, 1, 4'h3);
        expectDis("cnt2", 2, 0);
        applyStimulus(1, 0, 1, 4'h3);
        expectDis("cnt1", 1, 0);
        applyStimulus(1, 0, 1, 4'h3);
        expectDis("cnt0", 0, 0);
        checkOutput("cnt0 BO", int'(boDis), 1);
        applyStimulus(1, 0, 1, 4'h3);
        expectDis("wrapF", 15, 1);
        expectEn("reload3", 3, 1);
        checkOutput("wrapF BO", int'(boDis), 0);
        applyStimulus(1, 0, 0, 4'h3);
        expectDis("holdF", 15, 0);

        // Reload mode from 1 with D=5.
        applyStimulus(1, 1, 0, 4'h1);
        expectEn("load1", 1, 0);
        applyStimulus(1, 0, 1, 4'h5);
        expectEn("rl0", 0, 0);
        applyStimulus(1, 0, 1, 4'h5);
        expectEn("rl5", 5, 1);
        applyStimulus(1, 0, 1, 4'h5);
        expectEn("rl4", 4, 0);

        // SP=0 suppresses underflow even with BO asserted.
        applyStimulus(1, 1, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 4'h0);
            expectDis("spGate", 0, 0);
            checkOutput("spGate BO", int'(boDis), 1);
        end
        applyStimulus(1, 0, 1, 4'h0);
        expectDis("spRelease", 15, 1);
        applyStimulus(1, 0, 0, 4'h0);
        expectDis("spAfter", 15, 0);

        // Load outranks underflow.
        applyStimulus(1, 1, 0, 4'h0);
        applyStimulus(1, 1, 1, 4'hA);
        expectDis("loadPri", 10, 0);
        expectEn("loadPri", 10, 0);

        // Asynchronous clear between edges while holding 7.
        applyStimulus(1, 1, 0, 4'h7);
        expectDis("load7", 7, 0);
        sd = 1'b0; bi = 1'b1;
        #2;
        cd = 1'b1;
        #1;
        expectDis("asyncClr", 0, 0);
        expectEn("asyncClr", 0, 0);
        @(negedge ck);
        #1;
        cd = 1'b0;
        @(posedge ck);
        #1;
        expectDis("afterClr", 15, 1);
        expectEn("afterClr", 7, 1);
        applyStimulus(0, 0, 0, 4'h0);

        // Two-stage cascade: 01, 00, FF.
        applyCascade(1, 1, 0, 8'h01);
        checkOutput("cas load01", int'({qHi, qLo}), 8'h01);
        applyCascade(1, 0, 1, 8'h01);
        checkOutput("cas 00", int'({qHi, qLo}), 8'h00);
        checkOutput("cas 00 BOlo", int'(boLo), 1);
        checkOutput("cas 00 BOhi", int'(boHi), 1);
        applyCascade(1, 0, 1, 8'h01);
        checkOutput("cas FF", int'({qHi, qLo}), 8'hFF);
        checkOutput("cas FF TClo", int'(tcLo), 1);
        checkOutput("cas FF TChi", int'(tcHi), 1);
        checkOutput("cas model FF", cv, 255);
        applyCascade(1, 0, 1, 8'h01);
        checkOutput("cas FE", int'({qHi, qLo}), 8'hFE);
        checkOutput("cas FE TChi", int'(tcHi), 0);
        applyCascade(0, 0, 0, 8'h00);

        @(negedge ck);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
